// File: rtl/sonar_pkg.sv
// Shared types and default timing constants for the sonar front end.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sonar_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  // 10 us trigger pulse, 60 ms trigger period, 40 ms echo saturation
  localparam int unsigned TRIG_CYCLES = CLK_HZ / 100_000;
  localparam int unsigned TRIG_PERIOD = (CLK_HZ / 1000) * 60;
  localparam int unsigned ECHO_MAX    = (CLK_HZ / 1000) * 40;

  typedef enum logic {
    TRIG,
    GAP
  } trig_state_t;

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    HOLD
  } echo_state_t;

endpackage

// File: rtl/my_sonar_if.sv
// Sonar pin and result bundle; master = sonar front end, slave = sensor/host side.
// Latency: n/a (wiring only).
// Backpressure: none; distance is a level, valid (SONAR_VALID_EN) is a 1-cycle strobe.
interface my_sonar_if;

  logic        echo;
  logic        trigger;
  logic [31:0] distance;
`ifdef SONAR_VALID_EN
  logic        valid;

  modport master (input echo, output trigger, output distance, output valid);
  modport slave  (output echo, input trigger, input distance, input valid);
`else
  modport master (input echo, output trigger, output distance);
  modport slave  (output echo, input trigger, input distance);
`endif

endinterface

// File: rtl/sonar_trigger_gen.sv
// Free-running trigger generator: TRIG_CYCLES high out of every TRIG_PERIOD clocks.
// Latency: trigger rises on the first clk edge after reset release (registered output).
// Backpressure: none; runs independently of echo activity.
module sonar_trigger_gen #(
  parameter int unsigned TRIG_CYCLES = sonar_pkg::TRIG_CYCLES,
  parameter int unsigned TRIG_PERIOD = sonar_pkg::TRIG_PERIOD
) (
  input  logic clk,
  input  logic reset,
  output logic trigger
);
  import sonar_pkg::*;

  trig_state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        trigger_q, trigger_d;

  // One period counter drives both the pulse width and the start-to-start period
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == TRIG_PERIOD - 1) ? '0 : cnt_q + 32'd1;
    trigger_d = (state_q == TRIG);
    case (state_q)
      TRIG:    if (cnt_q == TRIG_CYCLES - 1) state_d = GAP;
      GAP:     if (cnt_q == TRIG_PERIOD - 1) state_d = TRIG;
      default: state_d = TRIG;
    endcase
  end

  // State, counter and registered trigger output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TRIG;
      cnt_q     <= '0;
      trigger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trigger_q <= trigger_d;
    end
  end

  assign trigger = trigger_q;

endmodule

// File: rtl/my_sonar.sv
// HC-SR04 style front end: periodic trigger, echo width measured in clk cycles.
// Latency: distance (and valid under SONAR_VALID_EN) updates 3 clk after echo falls.
// Backpressure: none; distance holds the last result until the next completed pulse.
module my_sonar #(
  parameter int unsigned TRIG_CYCLES = sonar_pkg::TRIG_CYCLES,
  parameter int unsigned TRIG_PERIOD = sonar_pkg::TRIG_PERIOD,
  parameter int unsigned ECHO_MAX    = sonar_pkg::ECHO_MAX
) (
  input  logic      clk,
  input  logic      reset,
  my_sonar_if.master bus
);
  import sonar_pkg::*;

  logic        echo_m_q, echo_m_d;
  logic        echo_s_q, echo_s_d;
  logic        echo_p_q, echo_p_d;
  logic        echo_rise, echo_fall;
  echo_state_t st_q, st_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] distance_q, distance_d;
  logic        upd;
  logic [31:0] upd_val;
  logic        trig_w;

  sonar_trigger_gen #(
    .TRIG_CYCLES (TRIG_CYCLES),
    .TRIG_PERIOD (TRIG_PERIOD)
  ) u_trig (
    .clk     (clk),
    .reset   (reset),
    .trigger (trig_w)
  );

  // Two-stage synchronizer plus previous-sample register for edge detection
  always_comb begin
    echo_m_d = bus.echo;
    echo_s_d = echo_m_q;
    echo_p_d = echo_s_q;
  end

  assign echo_rise = echo_s_q & ~echo_p_q;
  assign echo_fall = ~echo_s_q & echo_p_q;

  // Echo FSM: count high cycles, publish on fall or on saturation
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    upd     = 1'b0;
    upd_val = cnt_q;
    case (st_q)
      IDLE: if (echo_rise) begin
        cnt_d = 32'd1;
        st_d  = MEAS;
      end
      MEAS: begin
        if (echo_fall) begin
          upd  = 1'b1;
          st_d = IDLE;
        end else if (cnt_q >= ECHO_MAX) begin
          upd     = 1'b1;
          upd_val = ECHO_MAX;
          st_d    = HOLD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLD:    if (echo_fall) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    distance_d = upd ? upd_val : distance_q;
  end

  // Sync chain resets high so an echo already high at release is never seen as a rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_m_q   <= 1'b1;
      echo_s_q   <= 1'b1;
      echo_p_q   <= 1'b1;
      st_q       <= IDLE;
      cnt_q      <= '0;
      distance_q <= '0;
    end else begin
      echo_m_q   <= echo_m_d;
      echo_s_q   <= echo_s_d;
      echo_p_q   <= echo_p_d;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      distance_q <= distance_d;
    end
  end

  assign bus.trigger  = trig_w;
  assign bus.distance = distance_q;

`ifdef SONAR_VALID_EN
  logic valid_q, valid_d;

  // Strobe rises together with the new distance value, one cycle wide
  always_comb begin
    valid_d = upd;
  end

  // Registered valid strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  assign bus.valid = valid_q;
`endif

endmodule

// File: tb/tb_my_sonar.sv
// Self-checking bench for my_sonar with shrunk timing parameters.
// Trigger checked every cycle against its period arithmetic; echo widths against min(width, ECHO_MAX).
// Echo driven on falling clk edges so each high sample counts exactly one clk.
module tb_my_sonar;

  localparam int TC = 5;
  localparam int TP = 40;
  localparam int EM = 100;

  logic clk;
  logic reset;

  my_sonar_if bus ();

  my_sonar #(
    .TRIG_CYCLES (TC),
    .TRIG_PERIOD (TP),
    .ECHO_MAX    (EM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_upd = 0;
  int          vcnt = 0;
  bit          chk_dist = 0;
  logic [31:0] exp_dist = '0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

`ifdef SONAR_VALID_EN
  always @(negedge clk) if (bus.valid === 1'b1) vcnt++;
`endif

  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: count edges since reset release, then check on the falling edge
  task tick;
    @(posedge clk);
    if (reset === 1'b1) cyc++;
    @(negedge clk);
    check("trigger", {31'b0, bus.trigger},
          (cyc >= 1 && ((cyc - 1) % TP) < TC) ? 32'd1 : 32'd0);
    if (chk_dist) check("distance_hold", bus.distance, exp_dist);
  endtask

  task gap(input int g);
    repeat (g) tick();
  endtask

  // Echo high for n sampled clocks, then expect min(n, EM) within 3 clocks of the fall
  task pulse(input int n, input string tag);
    chk_dist = 0;
    bus.echo = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (n > EM + 6 && i == EM + 4) check("sat_while_high", bus.distance, EM);
    end
    bus.echo = 1'b0;
    tick();
    tick();
    tick();
    exp_dist = (n > EM) ? EM : n;
    check(tag, bus.distance, exp_dist);
    n_upd++;
    chk_dist = 1;
  endtask

  initial begin
    reset    = 1'b0;
    bus.echo = 1'b0;
    #5;
    check("reset_distance", bus.distance, 32'd0);
    check("reset_trigger", {31'b0, bus.trigger}, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    exp_dist = '0;
    chk_dist = 1;

    // Trigger over two full periods, distance must stay 0 with no echo
    gap(80);

    pulse(60, "echo_a");
    gap(30);
    pulse(20, "echo_b");
    gap(50);
    pulse(150, "echo_sat");
    gap(10);
    pulse(1, "echo_one");
    gap(10);
    pulse(EM, "echo_at_max");
    gap(5);
    pulse(EM + 1, "echo_max_plus1");
    gap(5);

    repeat (12) begin
      pulse(int'($urandom_range(130, 1)), "echo_rand");
      gap(int'($urandom_range(20, 3)));
    end

    // Reset in the middle of a pulse; echo still high at release must be ignored
    chk_dist = 0;
    bus.echo = 1'b1;
    repeat (20) tick();
    reset = 1'b0;
    cyc   = 0;
    #1;
    check("rst_mid_distance", bus.distance, 32'd0);
    check("rst_mid_trigger", {31'b0, bus.trigger}, 32'd0);
    repeat (3) tick();
    reset    = 1'b1;
    exp_dist = '0;
    chk_dist = 1;
    repeat (30) tick();
    bus.echo = 1'b0;
    gap(5);
    pulse(7, "echo_after_rst");
    gap(5);

`ifdef SONAR_VALID_EN
    check("valid_count", 32'(vcnt), 32'(n_upd));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
